datapath: RTL and testbench
===========================

# datapath

32-bit single-bus CPU datapath: sixteen general registers, PC, HI/LO, MAR, MDR, Y, a 64-bit Z result register and a combinational ALU, all sharing one 32-bit internal bus. An external control unit, or a bench acting as one, sequences register transfers cycle by cycle with one-hot bus-drive and register-load strobes. It sits between the control unit and the memory interface (`Mdatain`).

## Interface
- No parameters.
- `clock`  in  1  rising-edge clock for every register.
- `clear`  in  1  synchronous, active-high reset.
- `Mdatain`  in  32  memory read data.
- `Read`  in  1  MDR input-mux select: 1 = `Mdatain`, 0 = bus.
- `IncPC`  in  1  forces ALU result to bus+1, overriding `opcode`.
- `Rin`  in  16  one-hot load enables; bit n loads Rn.
- `Rout`  in  16  one-hot bus drives; bit n drives Rn.
- `PCin`, `Zin`, `MDRin`, `MARin`, `Yin`, `HIin`, `LOin`  in  1 each  register load enables.
- `PCout`, `Zhighout`, `Zlowout`, `HIout`, `LOout`, `MDRout`, `Yout`  in  1 each  bus drives.
- `opcode`  in  5  ALU operation.
- `bus_out`  out  32  current bus value (debug; may be left unconnected).
- `mar_out`  out  32  MAR contents (memory address).

## Operation
- Bus mux, combinational, fixed priority: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, Y. No drive asserted → bus = 0.
- ALU operands: A = Y, B = bus. Result is 64 bits, loaded into Z when `Zin` = 1.
- Opcodes (hi:lo = Z[63:32]:Z[31:0]; hi = 0 unless stated):
  - 00011 add: A+B.
  - 00100 sub: A−B.
  - 00101 and.
  - 00110 or.
  - 00111 shr: logical A >> B[4:0].
  - 01000 shra: arithmetic A >> B[4:0].
  - 01001 shl: A << B[4:0].
  - 01010 ror: A rotated right by B[4:0].
  - 01011 rol: A rotated left by B[4:0].
  - 01111 mul: signed A×B, full 64-bit product.
  - 10000 div: lo = signed A/B, hi = A%B. B = 0 → Z = 0.
  - 10001 neg: −B.
  - 10010 not: ~B.
  - Any other opcode → Z = 0.
- `IncPC` = 1 → lo = bus+1, hi = 0, regardless of `opcode`.
- All arithmetic is 32-bit with wrap-around; no flags.
- MDR loads on `MDRin`: `Mdatain` when `Read` = 1, otherwise bus.
- R0 is an ordinary register.
- Simultaneous loads are all performed in the same edge from the same bus value.

## Timing
- Every register updates on the rising `clock` edge when its enable is high. All reads are combinational.
- Single-cycle transfer: asserting source-out and destination-in together moves the data on that clock edge.
- ALU result is ready in the same cycle; Z holds it after the edge on which `Zin` is high.
- `clear` = 1 at a rising edge sets R0–R15, PC, HI, LO, MAR, MDR, Y and Z to 0. `clear` overrides every load enable in that cycle.
- `bus_out` follows the drive strobes combinationally. After reset, `mar_out` = 0.

## Configuration
- `DATAPATH_MULDIV_EN` defined: mul (01111) and div (10000) are implemented as above.
- Not defined: no multiplier or divider hardware; those opcodes produce Z = 0.

## Test plan
- Register load: `Mdatain` = 0x12, `Read` = 1 + `MDRin` one cycle, then `MDRout` + `Rin[3]` → R3 = 0x12. Load R5 = 0x14 and R1 = 0x18 the same way.
- shr: R3out + `Yin`, then R5out + opcode 00111 + `Zin`, then `Zlowout` + `Rin[1]` → R1 = 0x00000000. Repeat with R5 = 2 → R1 = 0x00000004.
- PC increment: PC = 0, `PCout` + `MARin` + `IncPC` + `Zin` → `mar_out` = 0, Z low = 1; then `Zlowout` + `PCin` → PC = 1.
- Rotate/arith: Y = 0x80000001, B = 1. ror → 0xC0000000; shra → 0xC0000000; rol → 0x00000003.
- Mul/div (macro on): Y = 0xFFFFFFFE, B = 3. mul → Z = 0xFFFFFFFF_FFFFFFFA. Y = 7, B = 2: div → lo = 3, hi = 1. Divide by B = 0 → Z = 0. With macro off, mul gives Z = 0.
- Reset: `clear` pulsed while `Rin` = 0xFFFF and `MDRout` asserted → all registers 0 after the edge. With no drive strobes, `bus_out` = 0.

Source files
------------

// File: rtl/datapath_if.sv
// Control-unit-to-datapath strobe bundle plus the bus/MAR observation outputs.
interface datapath_if;
    logic [31:0] Mdatain;
    logic        Read;
    logic        IncPC;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin;
    logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Yout;
    logic [4:0]  opcode;
    logic [31:0] bus_out;
    logic [31:0] mar_out;

    modport master (
        output Mdatain, Read, IncPC, Rin, Rout,
               PCin, Zin, MDRin, MARin, Yin, HIin, LOin,
               PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Yout, opcode,
        input  bus_out, mar_out
    );

    modport slave (
        input  Mdatain, Read, IncPC, Rin, Rout,
               PCin, Zin, MDRin, MARin, Yin, HIin, LOin,
               PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Yout, opcode,
        output bus_out, mar_out
    );
endinterface

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: register file, PC, HI/LO, MAR, MDR, Y, 64-bit Z and ALU.
// Define DATAPATH_MULDIV_EN to build the signed multiplier and divider.
module datapath (
    input  logic       clock,
    input  logic       clear,
    datapath_if.slave  dp
);
    typedef enum logic [4:0] {
        OP_ADD  = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR  = 5'b00110,
        OP_SHR  = 5'b00111, OP_SHRA = 5'b01000, OP_SHL = 5'b01001, OP_ROR = 5'b01010,
        OP_ROL  = 5'b01011, OP_MUL = 5'b01111, OP_DIV = 5'b10000, OP_NEG = 5'b10001,
        OP_NOT  = 5'b10010
    } op_e;

    logic [15:0][31:0] r_q;
    logic [31:0]       pc_q, hi_q, lo_q, mar_q, mdr_q, y_q;
    logic [63:0]       z_q, z_d;
    logic [31:0]       bus;
    logic [31:0]       mdr_d;
    logic [4:0]        sh;
    logic [5:0]        rol_amt;

    // Lowest-priority source is assigned first so later matches override it.
    always_comb begin
        bus = '0;
        if (dp.Yout)     bus = y_q;
        if (dp.MDRout)   bus = mdr_q;
        if (dp.PCout)    bus = pc_q;
        if (dp.Zlowout)  bus = z_q[31:0];
        if (dp.Zhighout) bus = z_q[63:32];
        if (dp.LOout)    bus = lo_q;
        if (dp.HIout)    bus = hi_q;
        for (int i = 15; i >= 0; i--)
            if (dp.Rout[i]) bus = r_q[i];
    end

`ifdef DATAPATH_MULDIV_EN
    logic [63:0]        mul_a, mul_b;
    logic signed [32:0] div_a, div_b;
    logic [31:0]        quo, rem;

    // 33-bit signed division keeps the most-negative / -1 case from overflowing.
    always_comb begin
        mul_a = {{32{y_q[31]}}, y_q};
        mul_b = {{32{bus[31]}}, bus};
        div_a = {y_q[31], y_q};
        div_b = {bus[31], bus};
        quo   = '0;
        rem   = '0;
        if (bus != 32'd0) begin
            quo = 32'(div_a / div_b);
            rem = 32'(div_a % div_b);
        end
    end
`endif

    assign sh      = bus[4:0];
    assign rol_amt = 6'd32 - {1'b0, sh};

    always_comb begin
        z_d = '0;
        if (dp.IncPC) begin
            z_d[31:0] = bus + 32'd1;
        end else begin
            case (dp.opcode)
                OP_ADD:  z_d[31:0] = y_q + bus;
                OP_SUB:  z_d[31:0] = y_q - bus;
                OP_AND:  z_d[31:0] = y_q & bus;
                OP_OR:   z_d[31:0] = y_q | bus;
                OP_SHR:  z_d[31:0] = y_q >> sh;
                OP_SHRA: z_d[31:0] = 32'($signed(y_q) >>> sh);
                OP_SHL:  z_d[31:0] = y_q << sh;
                OP_ROR:  z_d[31:0] = 32'({y_q, y_q} >> sh);
                OP_ROL:  z_d[31:0] = 32'({y_q, y_q} >> rol_amt);
`ifdef DATAPATH_MULDIV_EN
                OP_MUL:  z_d = mul_a * mul_b;
                OP_DIV:  z_d = {rem, quo};
`endif
                OP_NEG:  z_d[31:0] = -bus;
                OP_NOT:  z_d[31:0] = ~bus;
                default: z_d = '0;
            endcase
        end
    end

    assign mdr_d = dp.Read ? dp.Mdatain : bus;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_q   <= '0;
            pc_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < 16; i++)
                if (dp.Rin[i]) r_q[i] <= bus;
            if (dp.PCin)  pc_q  <= bus;
            if (dp.HIin)  hi_q  <= bus;
            if (dp.LOin)  lo_q  <= bus;
            if (dp.MARin) mar_q <= bus;
            if (dp.MDRin) mdr_q <= mdr_d;
            if (dp.Yin)   y_q   <= bus;
            if (dp.Zin)   z_q   <= z_d;
        end
    end

    assign dp.bus_out = bus;
    assign dp.mar_out = mar_q;
endmodule

// File: tb/tb_datapath.sv
// Directed test-plan steps followed by random register-transfer cycles against a behavioural model.
module tb_datapath;
    logic clock = 1'b0;
    logic clear = 1'b0;
    datapath_if dif();

    datapath u_dut (.clock(clock), .clear(clear), .dp(dif));

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_hi, m_lo, m_mar, m_mdr, m_y;
    logic [63:0] m_z;

    int ops [13] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic clr_strobes();
        dif.Read = 0; dif.IncPC = 0; dif.Rin = '0; dif.Rout = '0;
        dif.PCin = 0; dif.Zin = 0; dif.MDRin = 0; dif.MARin = 0; dif.Yin = 0;
        dif.HIin = 0; dif.LOin = 0; dif.PCout = 0; dif.Zhighout = 0; dif.Zlowout = 0;
        dif.HIout = 0; dif.LOout = 0; dif.MDRout = 0; dif.Yout = 0; dif.opcode = '0;
        clear = 0;
    endtask

    // Source numbering: 0..15 = R0..R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 Y.
    task automatic set_src(input int s);
        if (s < 16) dif.Rout[s] = 1'b1;
        else case (s)
            16: dif.HIout = 1;    17: dif.LOout = 1;   18: dif.Zhighout = 1;
            19: dif.Zlowout = 1;  20: dif.PCout = 1;   21: dif.MDRout = 1;
            default: dif.Yout = 1;
        endcase
    endtask

    function automatic logic [31:0] m_bus();
        for (int i = 0; i < 16; i++) if (dif.Rout[i]) return m_r[i];
        if (dif.HIout)    return m_hi;
        if (dif.LOout)    return m_lo;
        if (dif.Zhighout) return m_z[63:32];
        if (dif.Zlowout)  return m_z[31:0];
        if (dif.PCout)    return m_pc;
        if (dif.MDRout)   return m_mdr;
        if (dif.Yout)     return m_y;
        return 32'd0;
    endfunction

    function automatic logic [63:0] ref_alu(input int op, input logic inc,
                                            input logic [31:0] a, input logic [31:0] b);
        int s;
        logic [31:0] t;
        longint p, q, r;
        s = int'(b % 32);
        t = a;
        if (inc) return {32'd0, b + 32'd1};
        case (op)
            3:  return {32'd0, a + b};
            4:  return {32'd0, a - b};
            5:  return {32'd0, a & b};
            6:  return {32'd0, a | b};
            7:  begin repeat (s) t = {1'b0, t[31:1]};  return {32'd0, t}; end
            8:  begin repeat (s) t = {t[31], t[31:1]}; return {32'd0, t}; end
            9:  begin repeat (s) t = {t[30:0], 1'b0};  return {32'd0, t}; end
            10: begin repeat (s) t = {t[0], t[31:1]};  return {32'd0, t}; end
            11: begin repeat (s) t = {t[30:0], t[31]}; return {32'd0, t}; end
`ifdef DATAPATH_MULDIV_EN
            15: begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
            16: begin
                if (b == 0) return 64'd0;
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                return {r[31:0], q[31:0]};
            end
`endif
            17: return {32'd0, 32'd0 - b};
            18: return {32'd0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    // Applies the currently driven strobes for one clock edge, updating the model alongside.
    task automatic cyc();
        logic [31:0] b;
        logic [63:0] z;
        #1;
        b = m_bus();
        chk("bus", dif.bus_out, b);
        z = ref_alu(int'(dif.opcode), dif.IncPC, m_y, b);
        if (clear) begin
            foreach (m_r[i]) m_r[i] = 0;
            m_pc = 0; m_hi = 0; m_lo = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_z = 0;
        end else begin
            for (int i = 0; i < 16; i++) if (dif.Rin[i]) m_r[i] = b;
            if (dif.PCin)  m_pc  = b;
            if (dif.HIin)  m_hi  = b;
            if (dif.LOin)  m_lo  = b;
            if (dif.MARin) m_mar = b;
            if (dif.MDRin) m_mdr = dif.Read ? dif.Mdatain : b;
            if (dif.Yin)   m_y   = b;
            if (dif.Zin)   m_z   = z;
        end
        @(posedge clock);
        #1;
        chk("mar", dif.mar_out, m_mar);
        clr_strobes();
        @(negedge clock);
    endtask

    task automatic peek(input int src, input logic [31:0] exp, input string tag);
        clr_strobes();
        set_src(src);
        #1;
        chk(tag, dif.bus_out, exp);
        clr_strobes();
        @(negedge clock);
    endtask

    task automatic load_mdr(input logic [31:0] v);
        clr_strobes(); dif.Mdatain = v; dif.Read = 1; dif.MDRin = 1; cyc();
    endtask

    task automatic load_r(input int n, input logic [31:0] v);
        load_mdr(v);
        dif.MDRout = 1; dif.Rin[n] = 1; cyc();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v);
        dif.MDRout = 1; dif.Yin = 1; cyc();
    endtask

    task automatic alu_mdr(input logic [4:0] op, input logic [31:0] bval);
        load_mdr(bval);
        dif.MDRout = 1; dif.opcode = op; dif.Zin = 1; cyc();
    endtask

    initial begin
        logic [63:0] exp_mul;
        logic [31:0] exp_dlo, exp_dhi;
        foreach (m_r[i]) m_r[i] = 0;
        m_pc = 0; m_hi = 0; m_lo = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_z = 0;
        dif.Mdatain = '0;
        clr_strobes();

        // Reset overrides loads that are driven in the same cycle.
        clear = 1; dif.Rin = 16'hFFFF; dif.MDRout = 1; cyc();
        chk("reset_bus_idle", dif.bus_out, 32'd0);
        chk("reset_mar", dif.mar_out, 32'd0);
        for (int i = 0; i < 16; i++) peek(i, 32'd0, "reset_reg");

        load_r(3, 32'h12); load_r(5, 32'h14); load_r(1, 32'h18);
        peek(3, 32'h12, "load_r3");
        peek(5, 32'h14, "load_r5");
        peek(1, 32'h18, "load_r1");

        for (int k = 0; k < 2; k++) begin
            if (k == 1) load_r(5, 32'd2);
            dif.Rout[3] = 1; dif.Yin = 1; cyc();
            dif.Rout[5] = 1; dif.opcode = 5'b00111; dif.Zin = 1; cyc();
            dif.Zlowout = 1; dif.Rin[1] = 1; cyc();
            peek(1, (k == 0) ? 32'h0 : 32'h4, "shr_r1");
        end

        dif.PCout = 1; dif.MARin = 1; dif.IncPC = 1; dif.Zin = 1; cyc();
        chk("incpc_mar", dif.mar_out, 32'd0);
        peek(19, 32'd1, "incpc_zlo");
        peek(18, 32'd0, "incpc_zhi");
        dif.Zlowout = 1; dif.PCin = 1; cyc();
        peek(20, 32'd1, "incpc_pc");

        load_y(32'h8000_0001);
        alu_mdr(5'b01010, 32'd1); peek(19, 32'hC000_0000, "ror");
        alu_mdr(5'b01000, 32'd1); peek(19, 32'hC000_0000, "shra");
        alu_mdr(5'b01011, 32'd1); peek(19, 32'h0000_0003, "rol");
        alu_mdr(5'b01100, 32'd1); peek(19, 32'd0, "undef_op");

`ifdef DATAPATH_MULDIV_EN
        exp_mul = 64'hFFFF_FFFF_FFFF_FFFA; exp_dlo = 32'd3; exp_dhi = 32'd1;
`else
        exp_mul = 64'd0; exp_dlo = 32'd0; exp_dhi = 32'd0;
`endif
        load_y(32'hFFFF_FFFE);
        alu_mdr(5'b01111, 32'd3);
        peek(18, exp_mul[63:32], "mul_hi");
        peek(19, exp_mul[31:0], "mul_lo");
        load_y(32'd7);
        alu_mdr(5'b10000, 32'd2);
        peek(19, exp_dlo, "div_lo");
        peek(18, exp_dhi, "div_hi");
        alu_mdr(5'b10000, 32'd0);
        peek(19, 32'd0, "div0_lo");
        peek(18, 32'd0, "div0_hi");

        clear = 1; dif.Rin = 16'hFFFF; dif.MDRout = 1; cyc();
        peek(3, 32'd0, "reset2_r3");
        peek(19, 32'd0, "reset2_zlo");
        peek(22, 32'd0, "reset2_y");
        peek(20, 32'd0, "reset2_pc");

        // Random transfers: 0..2 drives, sparse destination set, random ALU op.
        for (int n = 0; n < 400; n++) begin
            int k;
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) set_src($urandom_range(0, 22));
            dif.Rin     = 16'($urandom) & 16'($urandom) & 16'($urandom);
            dif.PCin    = ($urandom_range(0, 5) == 0);
            dif.HIin    = ($urandom_range(0, 5) == 0);
            dif.LOin    = ($urandom_range(0, 5) == 0);
            dif.MARin   = ($urandom_range(0, 3) == 0);
            dif.MDRin   = ($urandom_range(0, 2) == 0);
            dif.Read    = $urandom_range(0, 1) == 1;
            dif.Mdatain = $urandom;
            dif.Yin     = ($urandom_range(0, 3) == 0);
            dif.Zin     = ($urandom_range(0, 1) == 1);
            dif.IncPC   = ($urandom_range(0, 9) == 0);
            dif.opcode  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(ops[$urandom_range(0, 12)]);
            clear       = ($urandom_range(0, 59) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
